// File: rtl/coin_acceptor.sv
// Coin-chute front end: synchronises the sensor, measures each pulse width and emits a coin code.
// Optional chute-jam detection is enabled by defining COIN_ACCEPTOR_JAM_DETECT_EN.
module coin_acceptor #(
    parameter int unsigned A_MIN       = 4,
    parameter int unsigned A_MAX       = 7,
    parameter int unsigned B_MIN       = 10,
    parameter int unsigned B_MAX       = 15,
    parameter int unsigned TIMEOUT     = 31,
    parameter int unsigned LOCKOUT_CYC = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_sense,
    input  logic       accept_en,
    output logic [1:0] x,
    output logic       reject,
    output logic       jam
);

`ifdef COIN_ACCEPTOR_JAM_DETECT_EN
    typedef enum logic [2:0] {StIdle, StMeasure, StEmit, StLockout, StJam} state_e;
`else
    typedef enum logic [1:0] {StIdle, StMeasure, StEmit, StLockout} state_e;
`endif

    localparam logic [7:0] WSat     = 8'(TIMEOUT + 1);
    localparam logic [7:0] AMin     = 8'(A_MIN);
    localparam logic [7:0] AMax     = 8'(A_MAX);
    localparam logic [7:0] BMin     = 8'(B_MIN);
    localparam logic [7:0] BMax     = 8'(B_MAX);
    localparam logic [7:0] LockLast = 8'(LOCKOUT_CYC - 1);

    state_e     state_q, state_d;
    logic       sync1_q, sense_s, sense_d;
    logic [7:0] wcnt_q, wcnt_d;
    logic [7:0] lcnt_q, lcnt_d;
    logic [1:0] x_q, x_d;
    logic       reject_q, reject_d;
    logic       rise, fall;

    assign rise = sense_s & ~sense_d;
    assign fall = ~sense_s & sense_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            sync1_q  <= 1'b0;
            sense_s  <= 1'b0;
            sense_d  <= 1'b0;
            wcnt_q   <= 8'd0;
            lcnt_q   <= 8'd0;
            x_q      <= 2'b00;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync1_q  <= coin_sense;
            sense_s  <= sync1_q;
            sense_d  <= sense_s;
            wcnt_q   <= wcnt_d;
            lcnt_q   <= lcnt_d;
            x_q      <= x_d;
            reject_q <= reject_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        lcnt_d   = lcnt_q;
        x_d      = 2'b00;
        reject_d = 1'b0;
        case (state_q)
            StIdle: begin
                // Only a fresh edge starts a measurement; a level held over from lockout does not.
                if (rise) begin
                    state_d = StMeasure;
                    wcnt_d  = 8'd1;
                end
            end
            StMeasure: begin
                if (fall) begin
                    state_d = StEmit;
                end else if (sense_s && (wcnt_q != WSat)) begin
                    wcnt_d = wcnt_q + 8'd1;
                end
`ifdef COIN_ACCEPTOR_JAM_DETECT_EN
                if (wcnt_q == WSat) begin
                    state_d = StJam;
                end
`endif
            end
            StEmit: begin
                if (!accept_en) begin
                    reject_d = 1'b1;
                end else if ((wcnt_q >= AMin) && (wcnt_q <= AMax)) begin
                    x_d = 2'b01;
                end else if ((wcnt_q >= BMin) && (wcnt_q <= BMax)) begin
                    x_d = 2'b10;
                end else begin
                    reject_d = 1'b1;
                end
                state_d = StLockout;
                lcnt_d  = 8'd0;
            end
            StLockout: begin
                if (lcnt_q == LockLast) begin
                    state_d = StIdle;
                end else begin
                    lcnt_d = lcnt_q + 8'd1;
                end
            end
`ifdef COIN_ACCEPTOR_JAM_DETECT_EN
            StJam: begin
                state_d = StJam;
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    assign x      = x_q;
    assign reject = reject_q;

`ifdef COIN_ACCEPTOR_JAM_DETECT_EN
    assign jam = (state_q == StJam);
`else
    assign jam = 1'b0;
`endif

endmodule
